ad_acq_sequencer: RTL and testbench
===================================

Name: ad_acq_sequencer

Overview:
- Sequences the parallel 16-bit ADC front end: power-up ADC reset, periodic conversion start, busy tracking, and a per-channel read burst.
- Each read word is pushed into the acquisition FIFO that feeds the filter chain.
- Sits between the ADC pins and the input FIFO; runs in the 50 MHz capture clock domain.
- Replaces the ad-hoc start/ad_reset/data_flag handshaking with one controller that owns sample timing and error reporting.

Parameters:
CHANNELS, 8, words read per conversion (1..8)
RST_CYC, 10, cycles ad_reset is held high during init
CONV_LOW, 2, cycles ad_convst is held low per conversion
SAMPLE_DIV, 1000, clk cycles between conversion starts (>= frame length)
RD_LOW, 2, cycles ad_rd_n is low per word
RD_HIGH, 2, cycles ad_rd_n is high between words
BUSY_TO, 500, max cycles from convst to busy fall before timeout

Ports:
clk  in  1  capture clock
reset  in  1  synchronous active-low reset
start  in  1  level; 1 enables acquisition, 0 stops after current frame
ad_busy  in  1  ADC busy, high during conversion
first_data  in  1  ADC first-channel marker, high while channel 0 is on the bus
ad_data  in  16  ADC parallel data
fifo_full  in  1  acquisition FIFO full
ad_reset  out  1  ADC reset, active high
ad_convst  out  1  conversion start, active low
ad_cs_n  out  1  ADC chip select, active low
ad_rd_n  out  1  ADC read strobe, active low
fifo_wrreq  out  1  single-cycle FIFO write
fifo_data  out  16  sample to FIFO
fifo_ch  out  3  channel index of fifo_data
data_flag  out  1  one-cycle pulse per captured word (same cycle as fifo_wrreq or drop)
ovr_cnt  out  16  dropped-word count, saturating
sync_err  out  1  sticky: first_data mismatch
busy_timeout  out  1  sticky: busy never fell within BUSY_TO

Behaviour:
- Reset (reset==0 at posedge clk): state INIT, counters 0. ad_reset=1, ad_convst=1, ad_cs_n=1, ad_rd_n=1, fifo_wrreq=0, fifo_data=0, fifo_ch=0, data_flag=0, ovr_cnt=0, sync_err=0, busy_timeout=0. Reset mid-frame aborts immediately and reruns INIT.
- INIT: ad_reset high for RST_CYC cycles, then low. Go to IDLE.
- IDLE: when start==1, go to CONV and load period counter with SAMPLE_DIV-1.
- Period counter decrements every cycle outside INIT. It reloads on each entry to CONV.
- CONV: ad_convst low for CONV_LOW cycles, then high. Go to WAIT_BUSY.
- WAIT_BUSY:
  - Waits for a ad_busy 1->0 edge (edge detect on a registered copy).
  - On the edge: go to READ with ch=0.
  - If BUSY_TO cycles elapse since CONV entry: set busy_timeout, go to IDLE with no words written.
- READ, per word:
  - ad_cs_n=0 for the whole burst; ad_rd_n low for RD_LOW cycles.
  - ad_data and first_data sampled on the last low cycle.
  - Next cycle: data_flag=1, fifo_data=sample, fifo_ch=ch, fifo_wrreq=!fifo_full.
  - If fifo_full: word dropped, ovr_cnt+1, saturating at 16'hFFFF.
  - ad_rd_n then high for RD_HIGH cycles. ch increments.
  - After word CHANNELS-1: ad_cs_n=1, go to GAP.
- first_data check: the sampled value must be 1 for ch==0 and 0 otherwise. On mismatch set sync_err; the word is still written.
- GAP: wait for period counter == 0.
  - At 0, if start==1: go to CONV (reload counter).
  - At 0, if start==0: go to IDLE.
  - If the counter already reached 0 before the frame ended, go to CONV on the first GAP cycle (no frame skipped, period stretched).
- Dropping start mid-frame completes the frame.
- Sticky flags clear only on reset.
- Latency: the first fifo_wrreq is RD_LOW+1 cycles after the busy falling edge is registered.

Test Plan:
- Reset then start=1, busy pulse 20 cycles, ad_data 0x0001..0x0008 per read -> ad_reset high exactly 10 cycles; 8 fifo_wrreq pulses, data 0x0001..0x0008, fifo_ch 0..7; second ad_convst falling edge 1000 cycles after the first.
- fifo_full=1 during words 3 and 4 of a frame -> fifo_wrreq low on those 2 cycles, data_flag still pulses 8 times, ovr_cnt=2.
- ad_busy held low after convst -> busy_timeout=1 at cycle 500 after CONV entry, no writes, next convst at the following period.
- first_data=1 on channel 2 instead of 0 -> sync_err=1; all 8 words still written.
- start deasserted during READ of word 4 -> remaining words written, no further ad_convst; restart with start=1 -> convst issued on the next cycle from IDLE.
- reset pulsed low during READ word 5 -> all outputs return to reset values the next cycle; ovr_cnt=0; INIT sequence repeats.

Source files
------------

// File: rtl/ad_acq_sequencer.sv
// Parallel 16-bit ADC acquisition sequencer: ADC reset, periodic conversion start,
// busy tracking and per-channel read burst into the acquisition FIFO.
module ad_acq_sequencer #(
   parameter int unsigned CHANNELS   = 8,
   parameter int unsigned RST_CYC    = 10,
   parameter int unsigned CONV_LOW   = 2,
   parameter int unsigned SAMPLE_DIV = 1000,
   parameter int unsigned RD_LOW     = 2,
   parameter int unsigned RD_HIGH    = 2,
   parameter int unsigned BUSY_TO    = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ad_busy,
   input  logic        first_data,
   input  logic [15:0] ad_data,
   input  logic        fifo_full,
   output logic        ad_reset,
   output logic        ad_convst,
   output logic        ad_cs_n,
   output logic        ad_rd_n,
   output logic        fifo_wrreq,
   output logic [15:0] fifo_data,
   output logic [2:0]  fifo_ch,
   output logic        data_flag,
   output logic [15:0] ovr_cnt,
   output logic        sync_err,
   output logic        busy_timeout
);

   localparam logic [15:0] RST_LAST    = 16'(RST_CYC - 1);
   localparam logic [15:0] CONV_LAST   = 16'(CONV_LOW - 1);
   localparam logic [15:0] RD_LOW_W    = 16'(RD_LOW);
   localparam logic [15:0] RD_CAPTURE  = 16'(RD_LOW - 1);
   localparam logic [15:0] RD_LAST     = 16'(RD_LOW + RD_HIGH - 1);
   localparam logic [15:0] PERIOD_LOAD = 16'(SAMPLE_DIV - 1);
   // Period counter value reached exactly BUSY_TO cycles after CONV entry.
   localparam logic [15:0] TO_MARK     = 16'(SAMPLE_DIV - BUSY_TO);
   localparam logic [2:0]  CH_LAST     = 3'(CHANNELS - 1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_CONV, S_WAIT_BUSY, S_READ, S_GAP
   } state_t;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [15:0] period, period_n;
   logic [2:0]  ch, ch_n;
   logic        busy_q, busy_qq, busy_fall;
   logic        capture, to_hit;
   logic        nxt_ad_reset, nxt_convst, nxt_cs_n, nxt_rd_n;

   assign busy_fall = busy_qq & ~busy_q;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 16'd1;
      ch_n    = ch;
      capture = 1'b0;
      to_hit  = 1'b0;
      unique case (state)
         S_INIT: begin
            if (cnt == RST_LAST) begin
               state_n = S_IDLE;
               cnt_n   = 16'd0;
            end
         end
         S_IDLE: begin
            cnt_n = 16'd0;
            // Honouring the remaining period keeps a timed-out frame on the sample grid.
            if (start && period == 16'd0) state_n = S_CONV;
         end
         S_CONV: begin
            if (cnt == CONV_LAST) begin
               state_n = S_WAIT_BUSY;
               cnt_n   = 16'd0;
            end
         end
         S_WAIT_BUSY: begin
            cnt_n = 16'd0;
            if (busy_fall) begin
               state_n = S_READ;
               ch_n    = 3'd0;
            end else if (period == TO_MARK) begin
               state_n = S_IDLE;
               to_hit  = 1'b1;
            end
         end
         S_READ: begin
            capture = (cnt == RD_CAPTURE);
            if (cnt == RD_LAST) begin
               cnt_n = 16'd0;
               if (ch == CH_LAST) state_n = S_GAP;
               else               ch_n    = ch + 3'd1;
            end
         end
         S_GAP: begin
            cnt_n = 16'd0;
            if (period == 16'd0) state_n = start ? S_CONV : S_IDLE;
         end
         default: begin
            state_n = S_INIT;
            cnt_n   = 16'd0;
         end
      endcase

      period_n = period;
      if (state_n == S_CONV && state != S_CONV) period_n = PERIOD_LOAD;
      else if (state != S_INIT && period != 16'd0) period_n = period - 16'd1;

      // NOTE: pin strobes are decoded from the next state and registered so the ADC never sees decode glitches.
      nxt_ad_reset = (state_n == S_INIT);
      nxt_convst   = (state_n != S_CONV);
      nxt_cs_n     = (state_n != S_READ);
      nxt_rd_n     = !((state_n == S_READ) && (cnt_n < RD_LOW_W));
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_INIT;
         cnt          <= 16'd0;
         period       <= 16'd0;
         ch           <= 3'd0;
         busy_q       <= 1'b0;
         busy_qq      <= 1'b0;
         ad_reset     <= 1'b1;
         ad_convst    <= 1'b1;
         ad_cs_n      <= 1'b1;
         ad_rd_n      <= 1'b1;
         fifo_wrreq   <= 1'b0;
         fifo_data    <= 16'd0;
         fifo_ch      <= 3'd0;
         data_flag    <= 1'b0;
         ovr_cnt      <= 16'd0;
         sync_err     <= 1'b0;
         busy_timeout <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         period     <= period_n;
         ch         <= ch_n;
         busy_q     <= ad_busy;
         busy_qq    <= busy_q;
         ad_reset   <= nxt_ad_reset;
         ad_convst  <= nxt_convst;
         ad_cs_n    <= nxt_cs_n;
         ad_rd_n    <= nxt_rd_n;
         fifo_wrreq <= capture & ~fifo_full;
         data_flag  <= capture;
         if (capture) begin
            fifo_data <= ad_data;
            fifo_ch   <= ch;
         end
         if (capture && fifo_full && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
         if (capture && (first_data != (ch == 3'd0))) sync_err <= 1'b1;
         if (to_hit) busy_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ad_acq_sequencer.sv
// Directed bench for ad_acq_sequencer: behavioural ADC model feeds a scoreboard
// of expected FIFO words; frame timing, drops, sync and timeout flags are checked.
`timescale 1ns/1ps
module tb_ad_acq_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, ad_busy, first_data, fifo_full;
   logic [15:0] ad_data;
   logic        ad_reset, ad_convst, ad_cs_n, ad_rd_n, fifo_wrreq, data_flag;
   logic [15:0] fifo_data, ovr_cnt;
   logic [2:0]  fifo_ch;
   logic        sync_err, busy_timeout;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  ch;
      logic        wr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc = 0;
   int   frame_no = 0;
   int   widx = 0;
   int   conv_cyc = 0;
   int   flags_tot = 0;
   int   wr_tot = 0;
   int   sync_ch = 0;
   bit   busy_stuck = 1'b0;
   logic [7:0] full_mask = 8'h00;

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   ad_acq_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .ad_busy(ad_busy),
      .first_data(first_data), .ad_data(ad_data), .fifo_full(fifo_full),
      .ad_reset(ad_reset), .ad_convst(ad_convst), .ad_cs_n(ad_cs_n), .ad_rd_n(ad_rd_n),
      .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_ch(fifo_ch),
      .data_flag(data_flag), .ovr_cnt(ovr_cnt), .sync_err(sync_err),
      .busy_timeout(busy_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ADC conversion model: busy rises after convst returns high, stays up 20 cycles.
   always begin
      @(negedge ad_convst);
      @(negedge clk);
      conv_cyc = cyc;
      frame_no++;
      widx = 0;
      @(posedge ad_convst);
      if (!busy_stuck) begin
         @(negedge clk);
         ad_busy = 1'b1;
         repeat (20) @(negedge clk);
         ad_busy = 1'b0;
      end
   end

   // ADC read model: each read strobe presents the next word and records what the FIFO should see.
   always begin
      @(negedge ad_rd_n);
      @(negedge clk);
      ad_data    = 16'((frame_no - 1) * 16 + widx + 1);
      first_data = (widx == sync_ch);
      fifo_full  = full_mask[widx[2:0]];
      sb.push_back('{data: ad_data, ch: 3'(widx), wr: !fifo_full});
      widx++;
   end

   // Output monitor: pops one expected word per data_flag pulse.
   always @(negedge clk) begin
      exp_t e;
      if (data_flag === 1'b1) begin
         flags_tot++;
         if (fifo_wrreq === 1'b1) wr_tot++;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected word: observed data %0h ch %0d, expected none", fifo_data, fifo_ch);
         end else begin
            e = sb.pop_front();
            check("fifo_data", 32'(fifo_data), 32'(e.data));
            check("fifo_ch", 32'(fifo_ch), 32'(e.ch));
            check("fifo_wrreq", 32'(fifo_wrreq), 32'(e.wr));
         end
      end else if (fifo_wrreq === 1'b1) begin
         check("wrreq without data_flag", 32'(fifo_wrreq), 32'd0);
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, " ad_reset"}, 32'(ad_reset), 32'd1);
      check({tag, " ad_convst"}, 32'(ad_convst), 32'd1);
      check({tag, " ad_cs_n"}, 32'(ad_cs_n), 32'd1);
      check({tag, " ad_rd_n"}, 32'(ad_rd_n), 32'd1);
      check({tag, " fifo_wrreq"}, 32'(fifo_wrreq), 32'd0);
      check({tag, " fifo_data"}, 32'(fifo_data), 32'd0);
      check({tag, " fifo_ch"}, 32'(fifo_ch), 32'd0);
      check({tag, " data_flag"}, 32'(data_flag), 32'd0);
      check({tag, " ovr_cnt"}, 32'(ovr_cnt), 32'd0);
      check({tag, " sync_err"}, 32'(sync_err), 32'd0);
      check({tag, " busy_timeout"}, 32'(busy_timeout), 32'd0);
   endtask

   task automatic count_init(input string tag);
      int n = 0;
      while (ad_reset === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(tag, 32'(n), 32'd10);
   endtask

   task automatic wait_frame(input int f, input int budget);
      for (int i = 0; i < budget && frame_no < f; i++) @(negedge clk);
      check($sformatf("reached frame %0d", f), 32'(frame_no >= f), 32'd1);
   endtask

   task automatic wait_flags(input int target, input int budget);
      for (int i = 0; i < budget && flags_tot < target; i++) @(negedge clk);
      check($sformatf("reached %0d words", target), 32'(flags_tot >= target), 32'd1);
   endtask

   task automatic wait_widx(input int target, input int budget);
      for (int i = 0; i < budget && widx < target; i++) @(negedge clk);
      check($sformatf("reached read %0d", target), 32'(widx >= target), 32'd1);
   endtask

   initial begin
      int c1, c4;
      reset = 1'b0; start = 1'b0; ad_busy = 1'b0;
      first_data = 1'b0; ad_data = 16'h0000; fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");

      // Power-up ADC reset pulse, then a clean frame.
      reset = 1'b1;
      count_init("init ad_reset cycles");
      start = 1'b1;
      wait_frame(1, 50);
      c1 = conv_cyc;
      wait_flags(8, 200);
      check("f1 writes", 32'(wr_tot), 32'd8);
      check("f1 ovr_cnt", 32'(ovr_cnt), 32'd0);
      check("f1 sync_err", 32'(sync_err), 32'd0);

      // Sample period, and FIFO full on words 3 and 4.
      wait_frame(2, 1100);
      check("convst period", 32'(conv_cyc - c1), 32'd1000);
      full_mask = 8'b0001_1000;
      wait_flags(16, 200);
      full_mask = 8'h00;
      check("f2 data_flag pulses", 32'(flags_tot), 32'd16);
      check("f2 writes", 32'(wr_tot), 32'd14);
      check("f2 ovr_cnt", 32'(ovr_cnt), 32'd2);

      // Channel marker on channel 2 instead of channel 0.
      sync_ch = 2;
      wait_frame(3, 1100);
      wait_flags(24, 200);
      sync_ch = 0;
      check("f3 sync_err", 32'(sync_err), 32'd1);
      check("f3 writes", 32'(wr_tot), 32'd22);
      check("f3 busy_timeout", 32'(busy_timeout), 32'd0);

      // Busy never asserts: timeout exactly BUSY_TO cycles after CONV entry.
      busy_stuck = 1'b1;
      wait_frame(4, 1100);
      c4 = conv_cyc;
      while (cyc < c4 + 499) @(negedge clk);
      check("busy_timeout before limit", 32'(busy_timeout), 32'd0);
      @(negedge clk);
      check("busy_timeout at limit", 32'(busy_timeout), 32'd1);
      busy_stuck = 1'b0;
      wait_frame(5, 1100);
      check("convst after timeout", 32'(conv_cyc - c4), 32'd1000);
      check("timeout frame words", 32'(flags_tot), 32'd24);

      // Stop during word 4: frame completes, no further conversions.
      wait_widx(5, 200);
      start = 1'b0;
      wait_flags(32, 200);
      check("f5 writes", 32'(wr_tot), 32'd30);
      repeat (1200) @(negedge clk);
      check("no convst while stopped", 32'(frame_no), 32'd5);
      check("convst idle high", 32'(ad_convst), 32'd1);
      start = 1'b1;
      @(negedge clk);
      check("convst on restart", 32'(ad_convst), 32'd0);

      // Reset during word 5 aborts the frame and reruns INIT.
      wait_frame(6, 10);
      wait_widx(6, 200);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_reset_values("mid-frame reset");
      sb.delete();
      reset = 1'b1;
      count_init("re-init ad_reset cycles");
      repeat (20) @(negedge clk);
      check("aborted frame words", 32'(flags_tot), 32'd37);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global time limit: observed no finish, expected finish");
      $fatal(1, "time limit");
   end

endmodule
